multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//  Main control FSM of the mp4 multicycle RV32I core. Decodes op/funct3 of the latched instruction,
//  sequences fetch/decode/execute/memory/writeback, and drives datapath selects incl. imm_src for the
//  immediate extender (I=000 S=001 B=010 J=011 U=100; R-type/none=111). Also handshakes with unified memory.
// PARAMETERS
//  MEM_TIMEOUT  0  max cycles waiting on mem_ready per access; 0 = wait forever; else overrun -> FAULT
// PORTS
//  clk          in   1  clock, all state on posedge
//  rst_n        in   1  synchronous active-low reset
//  op           in   7  instr[6:0] from instruction register
//  funct3       in   3  instr[14:12]
//  funct7b5     in   1  instr[30] (unused here except passthrough to ALU decoder via alu_op=10)
//  zero/lt/ltu  in   1  ALU flags of current-cycle SUB (eq, signed <, unsigned <)
//  mem_ready    in   1  memory completes access this cycle (ignored when mem_req=0)
//  mem_req      out  1  memory access active
//  mem_write    out  1  access is a store
//  adr_src      out  1  0=PC, 1=ALUOut
//  ir_write     out  1  latch fetched word into IR and PC into OldPC
//  pc_write     out  1  PC <= result bus
//  reg_write    out  1  rd <= result bus
//  alu_src_a    out  2  00=PC 01=OldPC 10=rs1 11=zero
//  alu_src_b    out  2  00=rs2 01=imm_ext 10=const 4
//  alu_op       out  2  00=ADD 01=SUB 10=funct-decoded
//  result_src   out  2  00=ALUOut 01=mem data 10=ALU result (direct)
//  imm_src      out  3  immediate format select, see PURPOSE
//  retire       out  1  1-cycle pulse on last cycle of each completed instruction
//  fault        out  1  sticky: illegal opcode/funct3 or memory timeout
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state<=FETCH, wait counter<=0, fault<=0. While rst_n=0 all enables
//    (mem_req,mem_write,ir_write,pc_write,reg_write,retire) forced 0. Reset mid-instruction abandons it.
//  - Outputs are Moore decodes of state, except pc_write/ir_write/retire gated by mem_ready/branch cond.
//  - Unlisted outputs default 0; imm_src is decoded from op in EVERY state (111 for R/unknown).
//  FETCH   : mem_req,adr_src=0,src_a=00,src_b=10,ADD,result_src=10; on mem_ready: ir_write,pc_write,->DECODE
//  DECODE  : src_a=01,src_b=01,ADD (ALUOut=OldPC+imm). load/store->MEMADR, R->EXEC_R, I-ALU->EXEC_I,
//            branch->BRANCH, jal->JAL, jalr->JALR_ADR, lui/auipc->UPPER, other->FAULT
//  MEMADR  : src_a=10,src_b=01,ADD; load->MEMREAD, store->MEMWRITE
//  MEMREAD : mem_req,adr_src=1; on mem_ready ->MEMWB
//  MEMWB   : result_src=01,reg_write,retire ->FETCH
//  MEMWRITE: mem_req,mem_write,adr_src=1; on mem_ready: retire ->FETCH
//  EXEC_R/EXEC_I: src_a=10, src_b=00/01, alu_op=10 ->ALUWB
//  ALUWB   : result_src=00,reg_write,retire ->FETCH
//  BRANCH  : src_a=10,src_b=00,SUB,result_src=00; pc_write=taken; retire ->FETCH.
//            taken: f3 000 zero,001 !zero,100 lt,101 !lt,110 ltu,111 !ltu
//  JAL     : src_a=01,src_b=10,ADD,result_src=00 (target),pc_write ->ALUWB (ALUOut now OldPC+4)
//  JALR_ADR: src_a=10,src_b=01,ADD ->JALR (datapath clears target bit0)
//  JALR    : identical outputs to JAL ->ALUWB
//  UPPER   : src_a=11 (lui) or 01 (auipc, op[5]=0),src_b=01,ADD ->ALUWB
//  FAULT   : fault=1, all enables 0, stays until reset
//  - Illegal funct3 -> FAULT from DECODE: branch 010/011, load 011/110/111, store >=011.
//  - Wait counter counts cycles with mem_req=1 & mem_ready=0, clears on ready/state change;
//    MEM_TIMEOUT>0 and counter==MEM_TIMEOUT-1 with no ready -> FAULT next cycle.
//  - CPI: ALU 4, branch 3, load 5, store 4, jal 4, jalr 5, lui/auipc 4 (zero-wait memory).
// TESTING
//  - add (op=0110011), mem_ready=1 -> FETCH,DECODE,EXEC_R,ALUWB; imm_src=111; reg_write+retire cycle 4 only
//  - lw with mem_ready low 3 cycles in MEMREAD -> stays in MEMREAD 4 cycles, then MEMWB reg_write,result_src=01
//  - beq f3=000: zero=1 -> pc_write=1 in BRANCH; zero=0 -> pc_write=0; both imm_src=010, retire=1
//  - jalr: JALR_ADR then JALR pc_write=1,result_src=00, then ALUWB reg_write; imm_src=000 throughout
//  - op=1111111 -> FAULT after DECODE, fault=1 sticky, no enables; rst_n=0 one cycle -> FETCH, fault=0
//  - MEM_TIMEOUT=4, mem_ready tied 0 in FETCH -> FAULT after 4 wait cycles; rst_n low mid-MEMWRITE -> mem_write=0 same cycle

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control/status bus between the multicycle RV32I controller and its datapath and unified memory.
// The controller sits on the master modport; the datapath/memory side uses slave.
interface multicycle_ctrl_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       lt;
    logic       ltu;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic [2:0] imm_src;
    logic       retire;
    logic       fault;

    modport master (
        input  op, funct3, funct7b5, zero, lt, ltu, mem_ready,
        output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, alu_op, result_src, imm_src, retire, fault
    );

    modport slave (
        output op, funct3, funct7b5, zero, lt, ltu, mem_ready,
        input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, alu_op, result_src, imm_src, retire, fault
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core: sequences fetch/decode/execute/memory/writeback,
// drives datapath selects, handshakes with unified memory and traps illegal encodings or memory timeouts.
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    multicycle_ctrl_if.master bus
);
    localparam int unsigned CW         = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam bit          TIMEOUT_EN = (MEM_TIMEOUT != 0);
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_EN ? (MEM_TIMEOUT - 1) : 0);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,   S_MEMREAD = 4'd3,
        S_MEMWB    = 4'd4,  S_MEMWRITE = 4'd5, S_EXEC_R = 4'd6,  S_EXEC_I  = 4'd7,
        S_ALUWB    = 4'd8,  S_BRANCH = 4'd9,  S_JAL    = 4'd10,  S_JALR_ADR = 4'd11,
        S_JALR     = 4'd12, S_UPPER  = 4'd13, S_FAULT  = 4'd14
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [CW-1:0] r_wait_cnt;
    logic [CW-1:0] w_next_wait;
    logic          w_timeout;
    logic          w_mem_req, w_mem_write, w_adr_src, w_ir_write, w_pc_write, w_reg_write, w_retire;
    logic [1:0]    w_alu_src_a, w_alu_src_b, w_alu_op, w_result_src;
    logic          w_unused_funct7b5;

    function automatic logic [2:0] imm_sel(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_IALU, OP_JALR: imm_sel = 3'b000;
            OP_STORE:                  imm_sel = 3'b001;
            OP_BRANCH:                 imm_sel = 3'b010;
            OP_JAL:                    imm_sel = 3'b011;
            OP_LUI, OP_AUIPC:          imm_sel = 3'b100;
            default:                   imm_sel = 3'b111;
        endcase
    endfunction

    function automatic logic funct3_legal(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            OP_BRANCH: funct3_legal = (f3 != 3'b010) && (f3 != 3'b011);
            OP_LOAD:   funct3_legal = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
            OP_STORE:  funct3_legal = (f3 < 3'b011);
            default:   funct3_legal = 1'b1;
        endcase
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic zero,
                                          input logic lt, input logic ltu);
        case (f3)
            3'b000:  branch_taken = zero;
            3'b001:  branch_taken = ~zero;
            3'b100:  branch_taken = lt;
            3'b101:  branch_taken = ~lt;
            3'b110:  branch_taken = ltu;
            3'b111:  branch_taken = ~ltu;
            default: branch_taken = 1'b0;
        endcase
    endfunction

    // funct7b5 is consumed by the ALU decoder, not by this FSM.
    assign w_unused_funct7b5 = bus.funct7b5;
    assign w_timeout = TIMEOUT_EN && !bus.mem_ready && (r_wait_cnt == LAST_WAIT);

    // State register and memory wait counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= {CW{1'b0}};
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_next_wait;
        end
    end

    // Next-state and Moore/gated output decode.
    always_comb begin
        w_next_state = r_state;
        w_mem_req    = 1'b0;
        w_mem_write  = 1'b0;
        w_adr_src    = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_retire     = 1'b0;
        w_alu_src_a  = 2'b00;
        w_alu_src_b  = 2'b00;
        w_alu_op     = 2'b00;
        w_result_src = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_mem_req    = 1'b1;
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
                if (bus.mem_ready) begin
                    w_ir_write   = 1'b1;
                    w_pc_write   = 1'b1;
                    w_next_state = S_DECODE;
                end else if (w_timeout) begin
                    w_next_state = S_FAULT;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_DECODE: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b01;
                if (!funct3_legal(bus.op, bus.funct3)) begin
                    w_next_state = S_FAULT;
                end else begin
                    case (bus.op)
                        OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
                        OP_R:              w_next_state = S_EXEC_R;
                        OP_IALU:           w_next_state = S_EXEC_I;
                        OP_BRANCH:         w_next_state = S_BRANCH;
                        OP_JAL:            w_next_state = S_JAL;
                        OP_JALR:           w_next_state = S_JALR_ADR;
                        OP_LUI, OP_AUIPC:  w_next_state = S_UPPER;
                        default:           w_next_state = S_FAULT;
                    endcase
                end
            end
            S_MEMADR: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                if (bus.op[5]) begin
                    w_next_state = S_MEMWRITE;
                end else begin
                    w_next_state = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                w_mem_req = 1'b1;
                w_adr_src = 1'b1;
                if (bus.mem_ready) begin
                    w_next_state = S_MEMWB;
                end else if (w_timeout) begin
                    w_next_state = S_FAULT;
                end else begin
                    w_next_state = S_MEMREAD;
                end
            end
            S_MEMWB: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                w_mem_req   = 1'b1;
                w_mem_write = 1'b1;
                w_adr_src   = 1'b1;
                if (bus.mem_ready) begin
                    w_retire     = 1'b1;
                    w_next_state = S_FETCH;
                end else if (w_timeout) begin
                    w_next_state = S_FAULT;
                end else begin
                    w_next_state = S_MEMWRITE;
                end
            end
            S_EXEC_R, S_EXEC_I: begin
                w_alu_src_a  = 2'b10;
                w_alu_src_b  = (r_state == S_EXEC_I) ? 2'b01 : 2'b00;
                w_alu_op     = 2'b10;
                w_next_state = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write  = 1'b1;
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_BRANCH: begin
                w_alu_src_a  = 2'b10;
                w_alu_op     = 2'b01;
                w_pc_write   = branch_taken(bus.funct3, bus.zero, bus.lt, bus.ltu);
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
            end
            // ALUOut still holds the target; the ALU concurrently forms OldPC+4 for the link.
            S_JAL, S_JALR: begin
                w_alu_src_a  = 2'b01;
                w_alu_src_b  = 2'b10;
                w_pc_write   = 1'b1;
                w_next_state = S_ALUWB;
            end
            S_JALR_ADR: begin
                w_alu_src_a  = 2'b10;
                w_alu_src_b  = 2'b01;
                w_next_state = S_JALR;
            end
            S_UPPER: begin
                w_alu_src_a  = bus.op[5] ? 2'b11 : 2'b01;
                w_alu_src_b  = 2'b01;
                w_next_state = S_ALUWB;
            end
            S_FAULT: begin
                w_next_state = S_FAULT;
            end
            default: begin
                w_next_state = S_FAULT;
            end
        endcase

        if (TIMEOUT_EN && w_mem_req && !bus.mem_ready && !w_timeout) begin
            w_next_wait = r_wait_cnt + CW'(1);
        end else begin
            w_next_wait = {CW{1'b0}};
        end
    end

    // Enables are forced low combinationally while reset is held.
    assign bus.mem_req    = rst_n & w_mem_req;
    assign bus.mem_write  = rst_n & w_mem_write;
    assign bus.ir_write   = rst_n & w_ir_write;
    assign bus.pc_write   = rst_n & w_pc_write;
    assign bus.reg_write  = rst_n & w_reg_write;
    assign bus.retire     = rst_n & w_retire;
    assign bus.adr_src    = w_adr_src;
    assign bus.alu_src_a  = w_alu_src_a;
    assign bus.alu_src_b  = w_alu_src_b;
    assign bus.alu_op     = w_alu_op;
    assign bus.result_src = w_result_src;
    assign bus.imm_src    = imm_sel(bus.op);
    assign bus.fault      = (r_state == S_FAULT);
endmodule
